// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read scheduler: FSM state encoding,
// RRESP codes and the default ID width.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int DEFAULT_ID_WIDTH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request strictly after
// 'last', wrapping, gets the one-hot grant; 'valid' flags that any request won.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index,
    output logic          valid
);

    always_comb begin
        gnt   = '0;
        index = '0;
        valid = 1'b0;
        // Offsets 1..N visit last+1 first and last itself at the end.
        for (int k = 1; k <= N; k++) begin
            int cand;
            cand = (int'(last) + k) % N;
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                index     = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_read_scheduler.sv
// Shares one AXI AR channel plus read-data-channel block among NUM_REQ clients.
// Optional data-phase watchdog with sticky 'timeout' output: AXI_READ_SCHED_TIMEOUT_EN.
module axi_read_scheduler
    import axi_rd_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = DEFAULT_ID_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]    req_len,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_error,
    output logic [ID_WIDTH-1:0]     ARID,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [7:0]              ARLEN,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic                    rd_go,
    input  logic                    rd_done,
    input  logic                    rd_error,
    input  logic [ID_WIDTH-1:0]     rd_id
`ifdef AXI_READ_SCHED_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t           state;
    logic [IW-1:0]    last;
    logic [IW-1:0]    idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_index;
    logic             arb_valid;

`ifdef AXI_READ_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]    tmo_cnt;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (req),
        .last  (last),
        .gnt   (arb_gnt),
        .index (arb_index),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            last      <= IW'(NUM_REQ - 1);
            idx       <= '0;
            grant     <= '0;
            req_done  <= '0;
            req_error <= '0;
            ARID      <= '0;
            ARADDR    <= '0;
            ARLEN     <= '0;
            ARVALID   <= 1'b0;
            rd_go     <= 1'b0;
`ifdef AXI_READ_SCHED_TIMEOUT_EN
            tmo_cnt   <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            req_done  <= '0;
            req_error <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant   <= arb_gnt;
                        idx     <= arb_index;
                        ARID    <= ID_WIDTH'(arb_index);
                        ARADDR  <= req_addr[arb_index*ADDR_WIDTH +: ADDR_WIDTH];
                        ARLEN   <= req_len[arb_index*8 +: 8];
                        ARVALID <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        rd_go   <= 1'b1;
                        last    <= idx;
                        state   <= DATA;
`ifdef AXI_READ_SCHED_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                DATA: begin
`ifdef AXI_READ_SCHED_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    if (rd_done || rd_error) begin
                        rd_go <= 1'b0;
                        state <= RELEASE;
                        // A done carrying someone else's ID is treated as a failure.
                        if (rd_error || (rd_id != ARID))
                            req_error[idx] <= 1'b1;
                        else
                            req_done[idx] <= 1'b1;
                    end
`ifdef AXI_READ_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        rd_go          <= 1'b0;
                        req_error[idx] <= 1'b1;
                        timeout        <= 1'b1;
                        state          <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    // One cycle of rd_go low lets the data-channel block return to idle.
                    grant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Directed self-checking bench for axi_read_scheduler (4 requesters).
// Covers the watchdog only when AXI_READ_SCHED_TIMEOUT_EN is defined.
module tb_axi_read_scheduler;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int IDW = 4;

    logic            clk;
    logic            resetn;
    logic [NR-1:0]   req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*8-1:0] req_len;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   req_done;
    logic [NR-1:0]   req_error;
    logic [IDW-1:0]  ARID;
    logic [AW-1:0]   ARADDR;
    logic [7:0]      ARLEN;
    logic            ARVALID;
    logic            ARREADY;
    logic            rd_go;
    logic            rd_done;
    logic            rd_error;
    logic [IDW-1:0]  rd_id;
`ifdef AXI_READ_SCHED_TIMEOUT_EN
    logic            timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] addr_tbl [NR];
    logic [7:0]    len_tbl  [NR];
    logic [1:0]    exp_q [$];

    axi_read_scheduler #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .ID_WIDTH       (IDW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .grant     (grant),
        .req_done  (req_done),
        .req_error (req_error),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .rd_go     (rd_go),
        .rd_done   (rd_done),
        .rd_error  (rd_error),
        .rd_id     (rd_id)
`ifdef AXI_READ_SCHED_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic reset_dut();
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        step();
    endtask

    task automatic wait_arvalid();
        int waited;
        waited = 0;
        while (ARVALID !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        check("arvalid_seen", ARVALID, 1);
    endtask

    // Services one transaction from AR issue to grant release.
    task automatic do_txn(input int exp_idx, input int ar_delay, input int data_cycles,
                          input logic dn, input logic er, input logic [IDW-1:0] id,
                          input logic exp_err, input logic drop_req);
        wait_arvalid();
        if (ARVALID !== 1'b1) return;
        check("grant", grant, onehot(exp_idx));
        check("arid", ARID, exp_idx);
        check("araddr", ARADDR, addr_tbl[exp_idx]);
        check("arlen", ARLEN, len_tbl[exp_idx]);
        check("rd_go_in_addr", rd_go, 0);
        for (int i = 0; i < ar_delay; i++) begin
            step();
            check("arvalid_hold", ARVALID, 1);
            check("araddr_hold", ARADDR, addr_tbl[exp_idx]);
            check("rd_go_early", rd_go, 0);
        end
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        if (drop_req) req = '0;
        check("arvalid_clr", ARVALID, 0);
        check("rd_go_set", rd_go, 1);
        for (int i = 1; i < data_cycles; i++) begin
            step();
            check("rd_go_hold", rd_go, 1);
            check("no_early_pulse", req_done | req_error, 0);
        end
        rd_done = dn;
        rd_error = er;
        rd_id = id;
        step();
        rd_done = 1'b0;
        rd_error = 1'b0;
        check("rd_go_drop", rd_go, 0);
        check("req_done", req_done, exp_err ? '0 : onehot(exp_idx));
        check("req_error", req_error, exp_err ? onehot(exp_idx) : '0);
        check("grant_in_release", grant, onehot(exp_idx));
        step();
        check("done_pulse_end", req_done, 0);
        check("error_pulse_end", req_error, 0);
        check("grant_clear", grant, 0);
        check("rd_go_idle", rd_go, 0);
    endtask

    initial begin
        resetn = 1'b0;
        req = '0;
        ARREADY = 1'b0;
        rd_done = 1'b0;
        rd_error = 1'b0;
        rd_id = '0;
        for (int i = 0; i < NR; i++) begin
            addr_tbl[i] = 32'h1000 * (i + 1);
            len_tbl[i] = 8'(3 + i);
            req_addr[i*AW +: AW] = addr_tbl[i];
            req_len[i*8 +: 8] = len_tbl[i];
        end
        reset_dut();

        // reset state
        check("rst_grant", grant, 0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_araddr", ARADDR, 0);
        check("rst_arlen", ARLEN, 0);
        check("rst_arid", ARID, 0);
        check("rst_rd_go", rd_go, 0);
        check("rst_pulses", req_done | req_error, 0);
`ifdef AXI_READ_SCHED_TIMEOUT_EN
        check("rst_timeout", timeout, 0);
`endif

        // stray ARREADY / rd_done / rd_error in IDLE are ignored
        ARREADY = 1'b1;
        rd_done = 1'b1;
        rd_error = 1'b1;
        step();
        step();
        ARREADY = 1'b0;
        rd_done = 1'b0;
        rd_error = 1'b0;
        check("idle_arvalid", ARVALID, 0);
        check("idle_rd_go", rd_go, 0);
        check("idle_pulses", req_done | req_error, 0);

        // single request, requester 0, req dropped mid-transaction
        req = 4'b0001;
        step();
        check("latency_arvalid", ARVALID, 1);
        do_txn(0, 0, 4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

        // fairness: all four held for eight transactions
        reset_dut();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) exp_q.push_back(2'(i));
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            do_txn(int'(e), 0, 1 + (t % 3), 1'b1, 1'b0, 4'(e), 1'b0, 1'b0);
        end
        req = '0;
        check("fair_queue_empty", exp_q.size(), 0);

        // ARREADY stalled for five cycles
        reset_dut();
        req = 4'b0001;
        do_txn(0, 5, 2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

        // requester 2: done+error together, then done with wrong ID
        reset_dut();
        req = 4'b0100;
        do_txn(2, 0, 2, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
        do_txn(2, 1, 3, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
        // and a plain rd_error with matching ID
        do_txn(2, 0, 1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1);

        // reset in DATA while requester 1 owns the port
        reset_dut();
        req = 4'b0010;
        wait_arvalid();
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        check("pre_reset_rd_go", rd_go, 1);
        step();
        resetn = 1'b0;
        #1;
        check("async_rd_go", rd_go, 0);
        check("async_grant", grant, 0);
        check("async_arvalid", ARVALID, 0);
        req = 4'b1111;
        rd_done = 1'b1;
        rd_id = 4'd1;
        step();
        rd_done = 1'b0;
        check("reset_no_pulse", req_done | req_error, 0);
        resetn = 1'b1;
        do_txn(0, 0, 1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

`ifdef AXI_READ_SCHED_TIMEOUT_EN
        // watchdog: no completion for 16 DATA cycles
        reset_dut();
        req = 4'b0001;
        wait_arvalid();
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("tmo_rd_go_hold", rd_go, 1);
            check("tmo_not_yet", timeout, 0);
            step();
        end
        check("tmo_rd_go_drop", rd_go, 0);
        check("tmo_req_error", req_error, 4'b0001);
        check("tmo_flag", timeout, 1);
        req = '0;
        step();
        step();
        check("tmo_sticky", timeout, 1);
        check("tmo_grant_clear", grant, 0);
`else
        // without the watchdog DATA waits indefinitely
        reset_dut();
        req = 4'b1000;
        do_txn(3, 0, 40, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench watchdog expired");
    end

endmodule
